multicycle_cu: RTL and testbench
================================

MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter EXT_BRANCH, default 0; when 1, enables bne/blt/bge, otherwise only beq.
REQ-002 SHALL have parameter MEM_WAIT, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-003 SHALL have parameter CNT_W, default 32; width of the retired-instruction counter.
REQ-004 SHALL have ports, clock and reset first: clk in 1 clock; rst_n in 1 synchronous active-low reset.
REQ-005 SHALL have inputs: op in 7 opcode; funct3 in 3; funct7b5 in 1; Zero in 1 ALU zero flag; Lt in 1 ALU signed less-than flag; mem_ready in 1 memory access complete.
REQ-006 SHALL have 1-bit outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op.
REQ-007 SHALL have multi-bit outputs: ResultSrc 2; ALUSrcA 2; ALUSrcB 2; ImmSrc 2; ALUControl 3; state 4 (current state, debug); instret CNT_W (retired count).

Function
REQ-008 SHALL be an 11-state Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 SHALL go to FETCH.
REQ-009 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; holds while mem_ready=0, else goes to DECODE.
REQ-010 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL; any other op->FETCH with illegal_op=1 for that cycle only.
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD if op[5]=0, else MEMWRITE.
REQ-012 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready, then goes to MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then goes to FETCH.
REQ-013 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 on every cycle in the state; holds until mem_ready, then goes to FETCH.
REQ-014 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB. ALUWB: ResultSrc=00, RegWrite=1, then goes to FETCH.
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=taken; then goes to FETCH.
REQ-016 Branch taken rule: taken=Zero for funct3=000. With EXT_BRANCH=1, also 001->!Zero, 100->Lt, 101->!Lt. All other funct3, or EXT_BRANCH=0 with funct3!=000: not taken.
REQ-017 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then goes to ALUWB.
REQ-018 ImmSrc is a combinational function of op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-019 ALUControl from ALUOp: 00->000 (add); 01->001 (sub); 10->by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101; 110->011; 111->010; other->000.
REQ-020 Every control output not listed for a state SHALL be 0 in that state.
REQ-021 instret SHALL increment by 1, modulo 2^CNT_W, on each transition to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; illegal ops SHALL NOT be counted.
REQ-022 With MEM_WAIT=0, FETCH, MEMREAD and MEMWRITE SHALL each last exactly 1 cycle.
REQ-023 Per-instruction latency with mem_ready=1: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.

Reset
REQ-024 With rst_n=0 at a clk edge: state<=FETCH and instret<=0, including mid-instruction.
REQ-025 While rst_n=0: PCWrite, IRWrite, MemWrite, RegWrite and illegal_op SHALL be forced to 0.

Verification
REQ-026 Reset, then op=0110011, funct3=000, funct7b5=1, mem_ready=1 -> states 0,1,6,8,0; ALUControl=001 in EXECR; RegWrite=1 in ALUWB; instret=1.
REQ-027 op=0000011, mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB with RegWrite=1 and ResultSrc=01; lw takes 7 cycles total.
REQ-028 EXT_BRANCH=1, op=1100011, funct3=001, Zero=0 -> PCWrite=1 in BRANCH; same with EXT_BRANCH=0 -> PCWrite=0.
REQ-029 op=1111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, instret unchanged.
REQ-030 rst_n=0 during MEMWRITE with mem_ready=0 -> MemWrite=0 in the same cycle, state=0 after the edge, instret=0.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multicycle RISC-V style control unit.
// An 11-state Moore FSM sequences fetch, decode, memory, ALU, branch and jal
// steps. The state and a retired-instruction counter are registered. Control
// outputs are decoded from the current state and, in FETCH and BRANCH, from
// the memory handshake or the branch flags.
module multicycle_cu #(
  parameter int EXT_BRANCH = 0,
  parameter int MEM_WAIT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state_q;
  state_t     state_next;
  logic       mem_ok;
  logic       taken;
  logic       retire;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] instret_q;

  // Branch condition; the extended compares only exist when enabled.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = (EXT_BRANCH != 0) && !z;
      3'b100:  t = (EXT_BRANCH != 0) && lt;
      3'b101:  t = (EXT_BRANCH != 0) && !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // ALU operation select from the coarse ALUOp and the instruction fields.
  function automatic logic [2:0] alu_decode(input logic [1:0] aop,
                                            input logic [2:0] f3,
                                            input logic op5,
                                            input logic f7b5);
    logic [2:0] c;
    c = 3'b000;
    case (aop)
      2'b00: c = 3'b000;
      2'b01: c = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  c = (op5 && f7b5) ? 3'b001 : 3'b000;
          3'b010:  c = 3'b101;
          3'b110:  c = 3'b011;
          3'b111:  c = 3'b010;
          default: c = 3'b000;
        endcase
      end
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // Immediate format select, purely a function of the opcode.
  function automatic logic [1:0] imm_decode(input logic [6:0] o);
    logic [1:0] s;
    case (o)
      OP_STORE:  s = 2'b01;
      OP_BRANCH: s = 2'b10;
      OP_JAL:    s = 2'b11;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

  // Without memory wait states every access completes in one cycle.
  assign mem_ok = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign taken  = branch_taken(funct3, Zero, Lt);

  // Next-state selection.
  always_comb begin
    state_next = FETCH;
    case (state_q)
      FETCH:    state_next = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default:           state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = mem_ok ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ok ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH.
  assign retire = (state_next == FETCH) &&
                  ((state_q == MEMWB) || (state_q == MEMWRITE) ||
                   (state_q == ALUWB) || (state_q == BRANCH));

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_next;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Moore control decode; strobes are held low while reset is asserted.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ok;
        PCWrite   = mem_ok;
      end
      DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegal_op = !(op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                                  OP_BRANCH, OP_JAL});
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        PCWrite = taken;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign ALUControl = alu_decode(alu_op, funct3, op[5], funct7b5);
  assign ImmSrc     = imm_decode(op);
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: three configurations, driven one at a time with
// instruction-level stimulus; expected per-cycle outputs go into a queue and
// a negedge monitor compares them against the active instance.
module tb_multicycle_cu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n_a, f7_a, z_a, lt_a, mr_a;
  logic [6:0] op_a [3];
  logic [2:0] f3_a [3];
  logic [2:0] pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a;
  logic [1:0] rs_a [3];
  logic [1:0] asa_a [3];
  logic [1:0] asb_a [3];
  logic [1:0] imm_a [3];
  logic [2:0] alu_a [3];
  logic [3:0] st_a [3];
  logic [31:0] ir_a [3];

  // Instance 0: defaults. 1: extended branches, 4-bit counter. 2: no memory waits.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int EB = (g == 0) ? 0 : 1;
    localparam int MW = (g == 2) ? 0 : 1;
    localparam int CW = (g == 0) ? 32 : ((g == 1) ? 4 : 8);
    logic [CW-1:0] cnt;
    multicycle_cu #(.EXT_BRANCH(EB), .MEM_WAIT(MW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n_a[g]), .op(op_a[g]), .funct3(f3_a[g]),
      .funct7b5(f7_a[g]), .Zero(z_a[g]), .Lt(lt_a[g]), .mem_ready(mr_a[g]),
      .PCWrite(pcw_a[g]), .AdrSrc(adr_a[g]), .MemWrite(mw_a[g]),
      .IRWrite(irw_a[g]), .RegWrite(rw_a[g]), .illegal_op(ill_a[g]),
      .ResultSrc(rs_a[g]), .ALUSrcA(asa_a[g]), .ALUSrcB(asb_a[g]),
      .ImmSrc(imm_a[g]), .ALUControl(alu_a[g]), .state(st_a[g]),
      .instret(cnt));
    assign ir_a[g] = 32'(cnt);
  end

  int eb_c [3] = '{0, 1, 1};
  int mw_c [3] = '{1, 1, 0};
  int cw_c [3] = '{32, 4, 8};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  typedef struct {
    int          d;
    logic [20:0] ctl;
    logic [31:0] ir;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] m_instret [3];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  bit cur_f7, cur_z, cur_lt;

  // Expected control vector for one cycle, from the per-state output table.
  function automatic logic [20:0] exp_ctl(int st, bit rn, bit mr, int d);
    bit mre, pcw, adr, memw, irw, rw, ill, taken;
    logic [1:0] rs, asa, asb, imm, aop;
    logic [2:0] alu;
    mre = (mw_c[d] == 0) || mr;
    {pcw, adr, memw, irw, rw, ill} = '0;
    rs = 0; asa = 0; asb = 0; aop = 0;
    case (cur_f3)
      3'b000:  taken = cur_z;
      3'b001:  taken = (eb_c[d] != 0) && !cur_z;
      3'b100:  taken = (eb_c[d] != 0) && cur_lt;
      3'b101:  taken = (eb_c[d] != 0) && !cur_lt;
      default: taken = 1'b0;
    endcase
    case (st)
      0:  begin asb = 2; rs = 2; irw = mre; pcw = mre; end
      1:  begin asa = 1; asb = 1;
                ill = !(cur_op inside {LW, SW, RT, IT, BR, JL}); end
      2:  begin asa = 2; asb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; memw = 1; end
      6:  begin asa = 2; aop = 2; end
      7:  begin asa = 2; asb = 1; aop = 2; end
      8:  rw = 1;
      9:  begin asa = 2; aop = 1; pcw = taken; end
      10: begin asa = 1; asb = 2; pcw = 1; end
      default: ;
    endcase
    if (aop == 1) alu = 3'b001;
    else if (aop == 2)
      case (cur_f3)
        3'b000:  alu = (cur_op[5] && cur_f7) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    else alu = 3'b000;
    case (cur_op)
      SW: imm = 2'b01;
      BR: imm = 2'b10;
      JL: imm = 2'b11;
      default: imm = 2'b00;
    endcase
    if (!rn) {pcw, irw, memw, rw, ill} = '0;
    return {4'(st), pcw, adr, memw, irw, rw, ill, rs, asa, asb, imm, alu};
  endfunction

  // Drive one cycle on instance d and queue what it must show.
  task automatic cyc(int d, int st, bit rn, bit mr);
    exp_t e;
    logic [31:0] mask;
    rst_n_a[d] = rn; op_a[d] = cur_op; f3_a[d] = cur_f3; f7_a[d] = cur_f7;
    z_a[d] = cur_z; lt_a[d] = cur_lt; mr_a[d] = mr;
    mask = (cw_c[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw_c[d]) - 32'd1);
    e.d = d; e.ctl = exp_ctl(st, rn, mr, d); e.ir = m_instret[d] & mask;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // A state that waits on memory; mstall<0 picks random stalls (at most 3).
  task automatic mem_phase(int d, int st, int mstall);
    int n = 0;
    bit mr;
    do begin
      mr = (mstall >= 0) ? (n >= mstall) : (n >= 3 || $urandom_range(0, 2) != 0);
      cyc(d, st, 1'b1, mr);
      n++;
    end while (!(mw_c[d] == 0 || mr));
  endtask

  task automatic do_reset(int d);
    rst_n_a[d] = 1'b0; mr_a[d] = 1'b1;
    @(posedge clk); #1;
    m_instret[d] = 0;
    cyc(d, 0, 1'b0, 1'b1);
  endtask

  // One whole instruction: the state walk follows the instruction class.
  task automatic exec_instr(int d, logic [6:0] o, logic [2:0] f3, bit f7,
                            bit z, bit l, int mstall, bit rst_mid);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = l;
    mem_phase(d, 0, (mstall >= 0) ? 0 : -1);
    cyc(d, 1, 1'b1, 1'($urandom_range(0, 1)));
    case (o)
      LW: begin cyc(d, 2, 1, 1); mem_phase(d, 3, mstall); cyc(d, 4, 1, 1);
                m_instret[d]++; end
      SW: begin
        cyc(d, 2, 1, 1);
        if (rst_mid) begin
          cyc(d, 5, 1'b0, 1'b0);
          m_instret[d] = 0;
          return;
        end
        mem_phase(d, 5, mstall); m_instret[d]++;
      end
      RT: begin cyc(d, 6, 1, 1); cyc(d, 8, 1, 1); m_instret[d]++; end
      IT: begin cyc(d, 7, 1, 1); cyc(d, 8, 1, 1); m_instret[d]++; end
      BR: begin cyc(d, 9, 1, 1); m_instret[d]++; end
      JL: begin cyc(d, 10, 1, 1); cyc(d, 8, 1, 1); m_instret[d]++; end
      default: ;
    endcase
  endtask

  // Monitor: compare the active instance against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [20:0] act;
      e = q.pop_front();
      act = {st_a[e.d], pcw_a[e.d], adr_a[e.d], mw_a[e.d], irw_a[e.d],
             rw_a[e.d], ill_a[e.d], rs_a[e.d], asa_a[e.d], asb_a[e.d],
             imm_a[e.d], alu_a[e.d]};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl dut%0d t=%0t: got %h expected %h", e.d, $time, act, e.ctl);
      end
      checks++;
      if (ir_a[e.d] !== e.ir) begin
        errors++;
        $display("FAIL instret dut%0d t=%0t: got %0d expected %0d", e.d, $time,
                 ir_a[e.d], e.ir);
      end
    end
  end

  logic [6:0] ops [6] = '{LW, SW, RT, IT, BR, JL};

  initial begin
    rst_n_a = '0; f7_a = '0; z_a = '0; lt_a = '0; mr_a = '0;
    for (int i = 0; i < 3; i++) begin
      op_a[i] = '0; f3_a[i] = '0; m_instret[i] = '0;
    end
    cur_op = '0; cur_f3 = '0; cur_f7 = 0; cur_z = 0; cur_lt = 0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      do_reset(d);
      if (d == 0) begin
        exec_instr(0, RT, 3'b000, 1, 0, 0, 0, 0);
        exec_instr(0, LW, 3'b010, 0, 0, 0, 2, 0);
        exec_instr(0, BR, 3'b001, 0, 0, 0, 0, 0);
        exec_instr(0, 7'b1111111, 3'b000, 0, 0, 0, 0, 0);
        exec_instr(0, JL, 3'b000, 0, 0, 0, 0, 0);
        exec_instr(0, SW, 3'b010, 0, 0, 0, 1, 1);
      end else if (d == 1) begin
        exec_instr(1, BR, 3'b001, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 60; i++) begin
        int pick;
        logic [6:0] o;
        pick = $urandom_range(0, 6);
        o = (pick == 6) ? 7'($urandom) : ops[pick];
        exec_instr(d, o, 3'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), -1, 0);
      end
      rst_n_a[d] = 1'b0;
    end
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
